// File: rtl/alu_commit_stage_pkg.sv
// Shared ARM encoding constants for the execute/commit path: condition codes,
// data-processing opcodes, instruction field positions and the NZCV flag type.
package alu_commit_stage_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [3:0] OPC_AND = 4'b0000;
  localparam logic [3:0] OPC_EOR = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_RSB = 4'b0011;
  localparam logic [3:0] OPC_ADD = 4'b0100;
  localparam logic [3:0] OPC_ADC = 4'b0101;
  localparam logic [3:0] OPC_SBC = 4'b0110;
  localparam logic [3:0] OPC_RSC = 4'b0111;
  localparam logic [3:0] OPC_TST = 4'b1000;
  localparam logic [3:0] OPC_TEQ = 4'b1001;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_CMN = 4'b1011;
  localparam logic [3:0] OPC_ORR = 4'b1100;
  localparam logic [3:0] OPC_MOV = 4'b1101;
  localparam logic [3:0] OPC_BIC = 4'b1110;
  localparam logic [3:0] OPC_MVN = 4'b1111;

  localparam int INST_COND_MSB = 31;
  localparam int INST_COND_LSB = 28;
  localparam int INST_OPC_MSB  = 24;
  localparam int INST_OPC_LSB  = 21;
  localparam int INST_S_BIT    = 20;
  localparam int INST_RD_MSB   = 15;
  localparam int INST_RD_LSB   = 12;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Compare/test opcodes only set flags and never write Rd.
  function automatic logic opc_is_test(input logic [3:0] opc);
    return (opc == OPC_TST) || (opc == OPC_TEQ) || (opc == OPC_CMP) || (opc == OPC_CMN);
  endfunction

  function automatic logic opc_is_arith(input logic [3:0] opc);
    case (opc)
      OPC_SUB, OPC_RSB, OPC_ADD, OPC_ADC,
      OPC_SBC, OPC_RSC, OPC_CMP, OPC_CMN: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_commit_stage_cond_check.sv
// Combinational ARM condition-code evaluator; shared by commit and branch logic.
module cond_check
  import alu_commit_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0; // NV: never executes
    endcase
  end

endmodule

// File: rtl/alu_commit_stage.sv
// ALU commit stage: condition check, NZCV flag register, one-entry writeback buffer.
// Optional COMMIT_STATS_EN adds saturating executed/skipped instruction counters.
module alu_commit_stage
  import alu_commit_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              update_cpsr,
  input  logic              ignore_c,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_skipped,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v
`ifdef COMMIT_STATS_EN
  ,
  output logic [15:0]       exec_cnt,
  output logic [15:0]       skip_cnt
`endif
);

  logic              accept_s;
  logic              pass_s;
  logic [3:0]        opc_s;
  logic              inst_unused;
  nzcv_t             flags_d, flags_q;
  logic              wb_valid_d, wb_valid_q;
  logic              wb_en_d, wb_en_q;
  logic [REG_AW-1:0] wb_rd_d, wb_rd_q;
  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  logic              wb_skipped_d, wb_skipped_q;

  assign opc_s       = inst[INST_OPC_MSB:INST_OPC_LSB];
  assign inst_unused = ^{inst[27:25], inst[INST_S_BIT], inst[19:16], inst[11:0]};
  assign in_ready    = !wb_valid_q || wb_ready;
  assign accept_s    = in_valid && in_ready;

  cond_check u_cond_check (
    .cond (inst[INST_COND_MSB:INST_COND_LSB]),
    .n    (flags_q.n),
    .z    (flags_q.z),
    .c    (flags_q.c),
    .v    (flags_q.v),
    .pass (pass_s)
  );

  always_comb begin
    flags_d      = flags_q;
    wb_valid_d   = wb_valid_q;
    wb_en_d      = wb_en_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_skipped_d = wb_skipped_q;
    if (accept_s) begin
      wb_valid_d   = 1'b1;
      wb_rd_d      = inst[INST_RD_MSB:INST_RD_LSB];
      wb_data_d    = alu_out;
      wb_skipped_d = !pass_s;
      wb_en_d      = pass_s && !opc_is_test(opc_s);
      if (pass_s && update_cpsr) begin
        flags_d.n = alu_n;
        flags_d.z = alu_z;
        flags_d.c = ignore_c ? flags_q.c : alu_c;
        // Logical ops leave V alone; only add/subtract families produce overflow.
        flags_d.v = opc_is_arith(opc_s) ? alu_v : flags_q.v;
      end else begin
        flags_d = flags_q;
      end
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_skipped_q <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      wb_valid_q   <= wb_valid_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_skipped_q <= wb_skipped_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_en      = wb_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_skipped = wb_skipped_q;
  assign flag_n     = flags_q.n;
  assign flag_z     = flags_q.z;
  assign flag_c     = flags_q.c;
  assign flag_v     = flags_q.v;

`ifdef COMMIT_STATS_EN
  logic [15:0] exec_cnt_d, exec_cnt_q;
  logic [15:0] skip_cnt_d, skip_cnt_q;

  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (accept_s && pass_s && (exec_cnt_q != 16'hFFFF)) begin
      exec_cnt_d = exec_cnt_q + 16'd1;
    end else if (accept_s && !pass_s && (skip_cnt_q != 16'hFFFF)) begin
      skip_cnt_d = skip_cnt_q + 16'd1;
    end else begin
      exec_cnt_d = exec_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt_q <= 16'd0;
      skip_cnt_q <= 16'd0;
    end else begin
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign exec_cnt = exec_cnt_q;
  assign skip_cnt = skip_cnt_q;
`endif

endmodule

// File: tb/tb_alu_commit_stage.sv
// Self-checking bench for alu_commit_stage: spec-level model compared every cycle
// plus directed vectors with hand-computed expectations.
module tb_alu_commit_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] alu_out;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        update_cpsr;
  logic        ignore_c;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_skipped;
  logic        flag_n, flag_z, flag_c, flag_v;
`ifdef COMMIT_STATS_EN
  logic [15:0] exec_cnt, skip_cnt;
`endif

  int errors = 0;
  int checks = 0;

  alu_commit_stage #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .alu_out(alu_out),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .update_cpsr(update_cpsr), .ignore_c(ignore_c),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_skipped(wb_skipped),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
`ifdef COMMIT_STATS_EN
    , .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] opc,
                                     input logic s, input logic [3:0] rd);
    return {cond, 3'b000, opc, s, 4'h0, rd, 12'h000};
  endfunction

  // Condition truth table, straight from the ARM condition definitions. f = {N,Z,C,V}.
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c & !z;
      4'd9:  return !c | z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z & (n == v);
      4'd13: return z | (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model state: the single buffered entry and the committed flags.
  logic        m_valid, m_en, m_skip;
  logic [3:0]  m_rd;
  logic [31:0] m_data;
  logic [3:0]  m_flags;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_en <= 1'b0; m_skip <= 1'b0;
      m_rd <= 4'd0; m_data <= 32'd0; m_flags <= 4'b0000;
    end else if (in_valid && (!m_valid || wb_ready)) begin
      m_valid <= 1'b1;
      m_rd    <= inst[15:12];
      m_data  <= alu_out;
      m_skip  <= !cond_ok(inst[31:28], m_flags);
      m_en    <= cond_ok(inst[31:28], m_flags) && !(inst[24:21] inside {[4'd8:4'd11]});
      if (cond_ok(inst[31:28], m_flags) && update_cpsr)
        m_flags <= {alu_n, alu_z, ignore_c ? m_flags[1] : alu_c,
                    (inst[24:21] inside {[4'd2:4'd7], 4'd10, 4'd11}) ? alu_v : m_flags[0]};
    end else if (wb_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_in_ready", {31'd0, in_ready}, {31'd0, !m_valid || wb_ready});
      check("cmp_wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      check("cmp_flags", {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, m_flags});
      if (m_valid) begin
        check("cmp_wb_en", {31'd0, wb_en}, {31'd0, m_en});
        check("cmp_wb_rd", {28'd0, wb_rd}, {28'd0, m_rd});
        check("cmp_wb_data", wb_data, m_data);
        check("cmp_wb_skipped", {31'd0, wb_skipped}, {31'd0, m_skip});
      end
    end
  end

  task automatic drive(input logic [31:0] i, input logic [31:0] d, input logic [3:0] nzcv,
                       input logic upd, input logic ign);
    in_valid = 1'b1;
    inst = i; alu_out = d;
    {alu_n, alu_z, alu_c, alu_v} = nzcv;
    update_cpsr = upd; ignore_c = ign;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] flags4();
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    inst = 32'd0; alu_out = 32'd0;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
    update_cpsr = 1'b0; ignore_c = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
    check("rst_flags", {28'd0, flags4()}, 32'd0);

    // ADDS AL r1 producing zero with carry
    drive(mk(4'hE, 4'b0100, 1'b1, 4'd1), 32'd0, 4'b0110, 1'b1, 1'b0);
    check("adds_valid", {31'd0, wb_valid}, 32'd1);
    check("adds_en", {31'd0, wb_en}, 32'd1);
    check("adds_data", wb_data, 32'd0);
    check("adds_flags", {28'd0, flags4()}, 32'h6);

    // MOVEQ r3 back-to-back: Z=1 so it executes
    drive(mk(4'h0, 4'b1101, 1'b0, 4'd3), 32'h33, 4'b0000, 1'b0, 1'b0);
    check("moveq_rd", {28'd0, wb_rd}, 32'd3);
    check("moveq_en", {31'd0, wb_en}, 32'd1);
    check("moveq_skip", {31'd0, wb_skipped}, 32'd0);

    // MOVNES r4 fails; its flag update must be suppressed
    drive(mk(4'h1, 4'b1101, 1'b1, 4'd4), 32'h44, 4'b1111, 1'b1, 1'b0);
    check("movne_skip", {31'd0, wb_skipped}, 32'd1);
    check("movne_en", {31'd0, wb_en}, 32'd0);
    check("movne_flags", {28'd0, flags4()}, 32'h6);

    // CMP sets N and V, no writeback
    drive(mk(4'hE, 4'b1010, 1'b1, 4'd0), 32'hFFFF_FFF0, 4'b1001, 1'b1, 1'b0);
    check("cmp_en", {31'd0, wb_en}, 32'd0);
    check("cmp_flags", {28'd0, flags4()}, 32'h9);
    drive(mk(4'hA, 4'b1101, 1'b0, 4'd5), 32'h55, 4'b0000, 1'b0, 1'b0);
    check("ge_pass", {31'd0, wb_skipped}, 32'd0);
    drive(mk(4'hB, 4'b1101, 1'b0, 4'd6), 32'h66, 4'b0000, 1'b0, 1'b0);
    check("lt_fail", {31'd0, wb_skipped}, 32'd1);

    // Set C=1,V=1, then ANDS with ignore_c: C and V both held
    drive(mk(4'hE, 4'b0100, 1'b1, 4'd2), 32'h1, 4'b0011, 1'b1, 1'b0);
    check("setcv_flags", {28'd0, flags4()}, 32'h3);
    drive(mk(4'hE, 4'b0000, 1'b1, 4'd8), 32'h8000_0000, 4'b1000, 1'b1, 1'b1);
    check("ands_flags", {28'd0, flags4()}, 32'hB);

    // Backpressure: ORR r7 waits while the ANDS entry stalls
    wb_ready = 1'b0;
    in_valid = 1'b1; inst = mk(4'hE, 4'b1100, 1'b1, 4'd7); alu_out = 32'h77;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0100; update_cpsr = 1'b1; ignore_c = 1'b0;
    #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_rd_stable", {28'd0, wb_rd}, 32'd8);
      check("bp_data_stable", wb_data, 32'h8000_0000);
      check("bp_flags_stable", {28'd0, flags4()}, 32'hB);
    end
    wb_ready = 1'b1;
    #1 check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("bp_new_rd", {28'd0, wb_rd}, 32'd7);
    check("bp_new_valid", {31'd0, wb_valid}, 32'd1);
    check("bp_new_flags", {28'd0, flags4()}, 32'h5);
    idle();
    check("drain_valid", {31'd0, wb_valid}, 32'd0);

    // Sweep every condition code across several flag states
    for (int p = 0; p < 4; p++) begin
      logic [3:0] fl;
      fl = (p == 0) ? 4'b0000 : (p == 1) ? 4'b1010 : (p == 2) ? 4'b0111 : 4'b1101;
      drive(mk(4'hE, 4'b0101, 1'b1, 4'd9), 32'(p), fl, 1'b1, 1'b0);
      for (int cc = 0; cc < 16; cc++)
        drive(mk(4'(cc), 4'b1101, 1'b0, 4'(cc)), 32'h100 + 32'(cc), 4'b0000, 1'b0, 1'b0);
      check("nv_never", {31'd0, wb_skipped}, 32'd1);
    end

    // Reset while an entry is stalled: clears without a clock edge
    wb_ready = 1'b0;
    drive(mk(4'hE, 4'b0100, 1'b1, 4'd10), 32'hAA, 4'b1111, 1'b1, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("arst_flags", {28'd0, flags4()}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; wb_ready = 1'b1;
    idle();
    check("post_rst_valid", {31'd0, wb_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
